// File: rtl/mpq_cmd_sched_pkg.sv
// mpq_cmd_sched_pkg: command codes, FSM encoding and sizing shared by the scheduler and its bench.
package mpq_cmd_sched_pkg;

    localparam int PQ_CAP  = 32;
    localparam int PQ_NREQ = 2;
    localparam int CNT_W   = 6;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_EXTRACT  = 3'd1,
        CMD_INCREASE = 3'd2,
        CMD_INSERT   = 3'd3,
        CMD_WRITE    = 3'd4
    } cmd_e;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_BUILD,
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD,
        ST_WAIT,
        ST_FINISH,
        ST_DONE
    } state_e;

    // INCREASE addresses elements 1..count, so index 0 and anything past the tail are rejected.
    function automatic logic cmd_legal(logic [2:0] cmd, logic [7:0] idx,
                                       logic [CNT_W-1:0] cnt, logic [CNT_W-1:0] cap);
        return !(cmd > CMD_WRITE ||
                 (cmd == CMD_EXTRACT && cnt == '0) ||
                 (cmd == CMD_INSERT && cnt == cap) ||
                 (cmd == CMD_INCREASE && (idx == '0 || idx > 8'(cnt))));
    endfunction

endpackage

// File: rtl/mpq_cmd_sched_if.sv
// mpq_cmd_sched_if: load stream, requester commands and priority-queue command/status bundle.
interface mpq_cmd_sched_if;
    import mpq_cmd_sched_pkg::*;

    logic                          in_data_valid;
    logic [7:0]                    in_data;
    logic [PQ_NREQ-1:0]            req_valid;
    logic [PQ_NREQ-1:0][2:0]       req_cmd;
    logic [PQ_NREQ-1:0][7:0]       req_index;
    logic [PQ_NREQ-1:0][7:0]       req_value;
    logic [PQ_NREQ-1:0]            req_ready;
    logic [PQ_NREQ-1:0]            req_err;
    logic                          mpq_data_valid;
    logic [7:0]                    mpq_data;
    logic                          mpq_cmd_valid;
    logic [2:0]                    mpq_cmd;
    logic [7:0]                    mpq_index;
    logic [7:0]                    mpq_value;
    logic                          mpq_busy;
    logic                          mpq_done;
    logic [CNT_W-1:0]              count;
    logic                          sched_done;

    modport slave (
        input  in_data_valid, in_data, req_valid, req_cmd, req_index, req_value,
               mpq_busy, mpq_done,
        output req_ready, req_err, mpq_data_valid, mpq_data, mpq_cmd_valid,
               mpq_cmd, mpq_index, mpq_value, count, sched_done
    );

    modport master (
        output in_data_valid, in_data, req_valid, req_cmd, req_index, req_value,
               mpq_busy, mpq_done,
        input  req_ready, req_err, mpq_data_valid, mpq_data, mpq_cmd_valid,
               mpq_cmd, mpq_index, mpq_value, count, sched_done
    );

endinterface

// File: rtl/mpq_cmd_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer flips to the loser after every taken grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;

    always_comb gnt_o = &req_i ? (ptr_q ? 2'b10 : 2'b01) : req_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= 1'b0;
        else if (en_i && |req_i)
            ptr_q <= gnt_o[0];
    end

endmodule

// File: rtl/mpq_cmd_sched.sv
// mpq_cmd_sched: loads the priority queue, then arbitrates and validates requester commands to it.
module mpq_cmd_sched
    import mpq_cmd_sched_pkg::*;
#(
    parameter int CAP  = PQ_CAP,
    parameter int NREQ = PQ_NREQ
) (
    input logic             clk,
    input logic             rst,
    mpq_cmd_sched_if.slave  bus_if
);

    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [NREQ-1:0]  rdy_q, err_q, gnt;
    logic             dv_q, cv_q;
    logic [7:0]       data_q, idx_q, val_q, idx_s, val_s;
    logic [2:0]       cmd_q, cmd_s;
    logic             arb_en, take, legal, g, room;

    assign arb_en = state_q == ST_IDLE && !bus_if.mpq_busy;
    assign room   = count_q < CAP_C;

    // A requester that was just readied is masked so its held request is not granted twice.
    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (arb_en),
        .req_i (bus_if.req_valid & ~rdy_q),
        .gnt_o (gnt)
    );

    always_comb begin
        take  = arb_en && |gnt;
        g     = gnt[1];
        cmd_s = bus_if.req_cmd[g];
        idx_s = bus_if.req_index[g];
        val_s = bus_if.req_value[g];
        legal = cmd_legal(cmd_s, idx_s, count_q, CAP_C);
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_LOAD: begin
                count_d = bus_if.in_data_valid && room ? count_q + 1'b1 : count_q;
                state_d = !bus_if.in_data_valid && count_q != '0 ? ST_BUILD : ST_LOAD;
            end
            ST_BUILD:  state_d = bus_if.mpq_busy ? ST_BUILD : ST_IDLE;
            ST_IDLE:   state_d = take && legal ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: begin
                state_d = ST_HOLD;
                count_d = cmd_q == CMD_EXTRACT ? count_q - 1'b1 :
                          cmd_q == CMD_INSERT  ? count_q + 1'b1 : count_q;
            end
            ST_HOLD:   state_d = ST_WAIT;
            ST_WAIT:   state_d = bus_if.mpq_busy ? ST_WAIT :
                                 cmd_q == CMD_WRITE ? ST_FINISH : ST_IDLE;
            ST_FINISH: state_d = bus_if.mpq_done ? ST_DONE : ST_FINISH;
            default:   state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            count_q <= '0;
            rdy_q   <= '0;
            err_q   <= '0;
            dv_q    <= 1'b0;
            data_q  <= '0;
            cv_q    <= 1'b0;
            cmd_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdy_q   <= take ? gnt : '0;
            err_q   <= take && !legal ? gnt : '0;
            dv_q    <= state_q == ST_LOAD && bus_if.in_data_valid && room;
            cv_q    <= take && legal;
            if (state_q == ST_LOAD)
                data_q <= bus_if.in_data;
            if (take && legal) begin
                cmd_q <= cmd_s;
                idx_q <= idx_s;
                val_q <= val_s;
            end
        end
    end

    assign bus_if.req_ready      = rdy_q;
    assign bus_if.req_err        = err_q;
    assign bus_if.mpq_data_valid = dv_q;
    assign bus_if.mpq_data       = data_q;
    assign bus_if.mpq_cmd_valid  = cv_q;
    assign bus_if.mpq_cmd        = cmd_q;
    assign bus_if.mpq_index      = idx_q;
    assign bus_if.mpq_value      = val_q;
    assign bus_if.count          = count_q;
    assign bus_if.sched_done     = state_q == ST_DONE;

endmodule

// File: tb/tb_mpq_cmd_sched.sv
// tb_mpq_cmd_sched: randomized command traffic checked against a transaction-level queue model.
module tb_mpq_cmd_sched;
    import mpq_cmd_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpq_cmd_sched_if bus();

    mpq_cmd_sched #(.CAP(32), .NREQ(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus.slave)
    );

    int         n_cmp, n_bad, dv_cnt, cv_cnt, m_count, m_ptr, n_legal;
    bit         busy_rand;
    logic [7:0] dq[$];

    // Observes the queue-side strobes mid-cycle, well clear of the clock edges.
    always begin
        @(posedge clk);
        #2;
        if (bus.mpq_data_valid) begin
            dv_cnt++;
            dq.push_back(bus.mpq_data);
        end
        if (bus.mpq_cmd_valid)
            cv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_m(input int c, input int i);
        if (c > 4) return 0;
        if (c == 1 && m_count == 0) return 0;
        if (c == 3 && m_count == 32) return 0;
        if (c == 2 && (i == 0 || i > m_count)) return 0;
        return 1;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (busy_rand)
            bus.mpq_busy = ($urandom_range(0, 2) == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_data_valid = 1'b0;
        bus.in_data = '0;
        bus.req_valid = '0;
        bus.req_cmd = '0;
        bus.req_index = '0;
        bus.req_value = '0;
        bus.mpq_busy = 1'b1;
        bus.mpq_done = 1'b0;
        busy_rand = 1'b0;
        repeat (2) tick();
        chk("rst_state", 32'(dut.state_q), 32'(ST_LOAD));
        chk("rst_count", bus.count, 0);
        chk("rst_ready", {bus.req_ready, bus.req_err}, 0);
        chk("rst_strobes", {bus.mpq_data_valid, bus.mpq_cmd_valid, bus.sched_done}, 0);
        chk("rst_fields", {bus.mpq_cmd, bus.mpq_index, bus.mpq_value, bus.mpq_data}, 0);
        rst = 1'b0;
        m_count = 0;
        m_ptr = 0;
    endtask

    task automatic load(input int n);
        int base;
        logic [7:0] exp[$];
        base = dv_cnt;
        for (int k = 0; k < n; k++) begin
            tick();
            bus.in_data_valid = 1'b1;
            bus.in_data = 8'($urandom);
            if (k < 32) exp.push_back(bus.in_data);
        end
        tick();
        bus.in_data_valid = 1'b0;
        repeat (3) tick();
        chk("load_pulses", dv_cnt - base, exp.size());
        for (int k = 0; k < exp.size() && base + k < dq.size(); k++)
            chk("load_data", dq[base + k], exp[k]);
        m_count = exp.size();
        chk("load_count", bus.count, m_count);
        chk("build_state", 32'(dut.state_q), 32'(ST_BUILD));
        bus.mpq_busy = 1'b0;
        tick();
        chk("idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    endtask

    task automatic post(input int r, input int c, input int i, input int v);
        bus.req_cmd[r] = 3'(c);
        bus.req_index[r] = 8'(i);
        bus.req_value[r] = 8'(v);
        bus.req_valid[r] = 1'b1;
    endtask

    task automatic serve(output int r);
        int t, er, c;
        bit ok;
        logic [1:0] pend;
        pend = bus.req_valid;
        er = (pend == 2'b11) ? m_ptr : (pend[1] ? 1 : 0);
        t = 0;
        do begin
            tick();
            t++;
        end while (bus.req_ready == 0 && t < 400);
        if (bus.req_ready == 0) begin
            chk("ready_timeout", 0, 1);
            r = -1;
            return;
        end
        r = bus.req_ready[1] ? 1 : 0;
        chk("grant", r, er);
        c = int'(bus.req_cmd[r]);
        ok = legal_m(c, int'(bus.req_index[r]));
        chk("err", bus.req_err, ok ? 0 : (1 << r));
        chk("count", bus.count, m_count);
        chk("cmd_valid", bus.mpq_cmd_valid, ok);
        if (ok) begin
            chk("cmd", bus.mpq_cmd, bus.req_cmd[r]);
            chk("index", bus.mpq_index, bus.req_index[r]);
            chk("value", bus.mpq_value, bus.req_value[r]);
            n_legal++;
            m_count += (c == 3) - (c == 1);
        end
        m_ptr = 1 - r;
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic settle();
        busy_rand = 1'b0;
        bus.mpq_busy = 1'b0;
        repeat (4) tick();
        chk("settle_count", bus.count, m_count);
    endtask

    initial begin
        int r, c, i, cv0, lg0, seen;
        n_cmp = 0;
        n_bad = 0;
        n_legal = 0;
        do_reset();
        load(5);

        cv0 = cv_cnt;
        post(0, 0, 0, 0);
        post(1, 0, 0, 0);
        serve(r);
        chk("rr_order0", r, 0);
        post(0, 0, 0, 0);
        serve(r);
        chk("rr_order1", r, 1);
        post(1, 0, 0, 0);
        serve(r);
        chk("rr_order2", r, 0);
        serve(r);
        chk("rr_order3", r, 1);
        settle();
        chk("rr_pulses", cv_cnt - cv0, 4);

        post(0, 2, 6, 8'h11);
        serve(r);
        post(1, 2, 5, 8'hFF);
        serve(r);
        post(0, 2, 0, 8'h22);
        serve(r);
        settle();

        cv0 = cv_cnt;
        lg0 = n_legal;
        busy_rand = 1'b1;
        for (int n = 0; n < 80; n++) begin
            for (int q = 0; q < 2; q++)
                if (!bus.req_valid[q] && $urandom_range(0, 3) != 0) begin
                    c = $urandom_range(0, 7);
                    if (c == 4) c = 1;
                    i = (c == 2) ? $urandom_range(0, m_count + 1) : $urandom_range(0, 255);
                    post(q, c, i, $urandom_range(0, 255));
                end
            if (bus.req_valid == 0)
                post($urandom_range(0, 1), 3, 0, $urandom_range(0, 255));
            serve(r);
        end
        while (bus.req_valid != 0 && n_bad < 50)
            serve(r);
        settle();
        chk("rand_pulses", cv_cnt - cv0, n_legal - lg0);

        do_reset();
        load(1);
        post(0, 1, 0, 0);
        serve(r);
        settle();
        cv0 = cv_cnt;
        post(0, 1, 0, 0);
        serve(r);
        settle();
        chk("empty_no_strobe", cv_cnt - cv0, 0);
        chk("empty_count", bus.count, 0);

        do_reset();
        load(40);
        post(0, 3, 0, 8'h33);
        serve(r);
        post(1, 1, 0, 0);
        serve(r);
        post(0, 3, 0, 8'h44);
        serve(r);
        settle();
        chk("full_count", bus.count, 32);

        post(0, 4, 0, 0);
        serve(r);
        bus.mpq_busy = 1'b1;
        repeat (3) tick();
        chk("wait_state", 32'(dut.state_q), 32'(ST_WAIT));
        bus.mpq_busy = 1'b0;
        tick();
        chk("finish_state", 32'(dut.state_q), 32'(ST_FINISH));
        repeat (2) tick();
        chk("finish_hold", bus.sched_done, 0);
        bus.mpq_done = 1'b1;
        tick();
        chk("sched_done", bus.sched_done, 1);
        post(0, 0, 0, 0);
        post(1, 0, 0, 0);
        seen = 0;
        repeat (20) begin
            tick();
            if (bus.req_ready != 0) seen++;
        end
        chk("done_no_ready", seen, 0);
        chk("done_sticky", bus.sched_done, 1);

        do_reset();
        chk("done_cleared", bus.sched_done, 0);
        load(2);
        post(0, 3, 0, 8'h55);
        serve(r);
        bus.mpq_busy = 1'b1;
        repeat (2) tick();
        chk("wait_state2", 32'(dut.state_q), 32'(ST_WAIT));
        cv0 = cv_cnt;
        rst = 1'b1;
        #1;
        chk("abort_state", 32'(dut.state_q), 32'(ST_LOAD));
        chk("abort_strobe", bus.mpq_cmd_valid, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("abort_no_strobe", cv_cnt - cv0, 0);
        chk("abort_count", bus.count, 0);
        chk("abort_fields", {bus.mpq_cmd, bus.mpq_value}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mpq_cmd_sched.md
MPQ_CMD_SCHED -- requirements
Module: mpq_cmd_sched

Interface
REQ-001 The module SHALL have parameter CAP, default 32, giving the maximum element count of the downstream priority queue.
REQ-002 The module SHALL have parameter NREQ, fixed at 2, giving the number of command requesters.
REQ-003 clk  in  1  single clock; all state is updated on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 in_data_valid, in_data  in  1, 8  initial load stream, one element per cycle.
REQ-006 req_valid  in  2  per-requester command request.
REQ-007 req_cmd, req_index, req_value  in  2x3, 2x8, 2x8  per-requester command fields.
REQ-008 req_ready  out  2  one-cycle pulse when that requester's command is accepted.
REQ-009 req_err  out  2  one-cycle pulse, coincident with req_ready, when the command was rejected.
REQ-010 mpq_data_valid, mpq_data  out  1, 8  load stream to the queue, registered.
REQ-011 mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value  out  1, 3, 8, 8  command to the queue.
REQ-012 mpq_busy, mpq_done  in  1, 1  queue status.
REQ-013 count  out  6  current element count.
REQ-014 sched_done  out  1  high once the queue reports done.

Function
REQ-015 The FSM SHALL have states LOAD, BUILD, IDLE, ISSUE, HOLD, WAIT, FINISH and DONE; the state after reset SHALL be LOAD.
REQ-016 In LOAD, mpq_data_valid/mpq_data SHALL equal in_data_valid/in_data with one-cycle latency.
REQ-017 In LOAD, each valid element SHALL increment count, saturating at CAP; elements beyond CAP SHALL be dropped and SHALL NOT be forwarded.
REQ-018 The first cycle with in_data_valid=0 after at least one valid element SHALL move the FSM LOAD->BUILD.
REQ-019 BUILD SHALL move to IDLE on the first cycle mpq_busy=0.
REQ-020 In IDLE with mpq_busy=0, the FSM SHALL grant one valid requester round-robin: pointer 0 at reset; after a grant the pointer SHALL move to the other requester; a lone requester SHALL be granted regardless of the pointer.
REQ-021 A granted command SHALL be illegal if cmd>4, cmd=1 with count=0, cmd=3 with count=CAP, or cmd=2 with index=0 or index>count.
REQ-022 An illegal grant SHALL pulse req_ready and req_err, SHALL NOT drive the queue, and SHALL keep the FSM in IDLE.
REQ-023 A legal grant SHALL pulse req_ready, register the fields onto mpq_cmd/index/value and go to ISSUE.
REQ-024 In ISSUE, mpq_cmd_valid SHALL be 1 for exactly one cycle; count SHALL decrement for cmd 1 and increment for cmd 3 in that cycle.
REQ-025 The FSM SHALL go ISSUE->HOLD; HOLD SHALL last exactly one cycle with mpq_busy ignored; then WAIT.
REQ-026 WAIT SHALL return to IDLE on mpq_busy=0; for cmd 4 the FSM SHALL go to FINISH instead.
REQ-027 In FINISH the FSM SHALL move to DONE when mpq_done=1; in DONE sched_done=1 and req_ready SHALL stay 0 until reset.
REQ-028 Requests arriving in any state other than IDLE SHALL wait; req_valid SHALL be held by the requester until req_ready.
REQ-029 mpq_cmd/index/value SHALL hold their last values outside ISSUE.

Reset
REQ-030 Reset SHALL clear count, the pointer, req_ready, req_err, mpq_data_valid, mpq_cmd_valid, mpq_cmd/index/value/data and sched_done, and SHALL return the FSM to LOAD.
REQ-031 A reset asserted mid-command SHALL abort the command with no further queue strobe.

Structure
REQ-032 A shared package SHALL hold the command codes (NOP=0, EXTRACT=1, INCREASE=2, INSERT=3, WRITE=4), the FSM state encoding and CAP.
REQ-033 The round-robin arbiter SHALL be one sub-module, rr_arb2.

Verification
REQ-034 Load 5 elements then stop -> exactly 5 mpq_data_valid pulses, count=5, FSM in BUILD until mpq_busy=0.
REQ-035 Both requesters valid with cmd 0 for 4 grants -> grant order 0,1,0,1, with one mpq_cmd_valid each.
REQ-036 count=0 and requester 0 sends cmd 1 -> req_ready[0]=req_err[0]=1, no mpq_cmd_valid, count stays 0.
REQ-037 count=5 and cmd 2 with index 6 -> error; cmd 2 with index 5, value 8'hFF -> forwarded unchanged.
REQ-038 Load 32 elements then cmd 3 -> error; cmd 1 then cmd 3 -> both forwarded, count returns to 32.
REQ-039 cmd 4 then mpq_done=1 -> sched_done=1; later requests are never readied; rst asserted in WAIT -> FSM is in LOAD on the next edge.
